// File: rtl/key_press_conditioner_if.sv
// Key conditioner bus: raw buttons in, conditioned pulses and levels out.
// master drives key_raw; slave (the conditioner) drives everything else.
interface key_press_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_down;
  logic                any_down;
  logic                reject_pulse;

  modport master (
    output key_raw,
    input  key_pulse,
    input  key_down,
    input  any_down,
    input  reject_pulse
  );

  modport slave (
    input  key_raw,
    output key_pulse,
    output key_down,
    output any_down,
    output reject_pulse
  );
endinterface

// File: rtl/key_press_conditioner.sv
// Sync + debounce push-buttons, one pulse per accepted press, one key at a time.
// Ports: clock, reset (async, high), kif.slave (key_raw in; pulses/levels out).
module key_press_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  key_press_conditioner_if.slave kif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] REL = {NUM_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    HELD         = 2'd2
  } state_t;

  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;
  logic [NUM_KEYS-1:0] sample;
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] stable_d;
  logic [NUM_KEYS-1:0] prev_q;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic                any_q;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] lowest;
  logic [NUM_KEYS-1:0] pulse_q;
  logic                rej_q;
  state_t              state_q;

  // Synchroniser idles at the released raw level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= REL;
      sync2_q <= REL;
    end else begin
      sync1_q <= kif.key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sample[i] != stable_q[i]) begin
        if (cnt_q[i] == CMAX) stable_d[i] = sample[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Stable resets to pressed so a key held through reset never pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stable_q <= '1;
      prev_q   <= '1;
      any_q    <= 1'b1;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      any_q    <= |stable_d;
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise   = stable_q & ~prev_q;
  assign lowest = rise & (~rise + NUM_KEYS'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_RELEASE;
      pulse_q <= '0;
      rej_q   <= 1'b0;
    end else begin
      pulse_q <= '0;
      rej_q   <= 1'b0;
      case (state_q)
        WAIT_RELEASE: begin
          if (!any_q) state_q <= IDLE;
        end
        IDLE: begin
          if (|rise) begin
            pulse_q <= lowest;
            rej_q   <= |(rise & ~lowest);
            state_q <= HELD;
          end
        end
        HELD: begin
          if (|rise) rej_q <= 1'b1;
          if (!any_q) state_q <= IDLE;
        end
        default: state_q <= WAIT_RELEASE;
      endcase
    end
  end

  assign kif.key_pulse    = pulse_q;
  assign kif.key_down     = stable_q;
  assign kif.any_down     = any_q;
  assign kif.reject_pulse = rej_q;
endmodule

// File: tb/tb_key_press_conditioner.sv
// Bench for key_press_conditioner, DEBOUNCE_CYCLES=4, active-low keys.
// Table vectors plus hand sequences for bounce, hold, lockout and reset.
module tb_key_press_conditioner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int pcnt = 0;
  int rcnt = 0;
  int viol = 0;
  logic [3:0] lastp = '0;
  logic prev_nz = 1'b0;
  int base;
  int rbase;

  key_press_conditioner_if #(.NUM_KEYS(4)) kif ();

  key_press_conditioner #(
    .NUM_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kif(kif)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (kif.key_pulse != 0) begin
      pcnt++;
      lastp = kif.key_pulse;
      if (!$onehot(kif.key_pulse) || prev_nz) viol++;
    end
    prev_nz = kif.key_pulse != 0;
    if (kif.reject_pulse) rcnt++;
  end

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] down;
    logic [3:0] pulse;
    logic       rej;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    tbl[0]  = '{4'hF, 6, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hE, 5, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'hE, 1, 4'h1, 4'h0, 1'b0};
    tbl[3]  = '{4'hE, 1, 4'h1, 4'h1, 1'b0};
    tbl[4]  = '{4'hE, 1, 4'h1, 4'h0, 1'b0};
    tbl[5]  = '{4'hE, 6, 4'h1, 4'h0, 1'b0};
    tbl[6]  = '{4'hF, 6, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'hF, 2, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'h5, 6, 4'hA, 4'h0, 1'b0};
    tbl[9]  = '{4'h5, 1, 4'hA, 4'h2, 1'b1};
    tbl[10] = '{4'h5, 1, 4'hA, 4'h0, 1'b0};
    tbl[11] = '{4'hF, 8, 4'h0, 4'h0, 1'b0};

    kif.key_raw = 4'hF;
    step(3);
    chk("rst_pulse", kif.key_pulse, 4'h0);
    chk("rst_rej", kif.reject_pulse, 1'b0);
    chk("rst_down", kif.key_down, 4'hF);
    chk("rst_any", kif.any_down, 1'b1);
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      kif.key_raw = tbl[v].raw;
      step(tbl[v].n);
      chk($sformatf("v%0d_down", v), kif.key_down, tbl[v].down);
      chk($sformatf("v%0d_pulse", v), kif.key_pulse, tbl[v].pulse);
      chk($sformatf("v%0d_rej", v), kif.reject_pulse, tbl[v].rej);
      chk($sformatf("v%0d_any", v), kif.any_down, |tbl[v].down);
    end
    chk("tbl_pcnt", pcnt, 2);

    // Held key: one pulse in 200 cycles, another only after re-press.
    base = pcnt;
    kif.key_raw = 4'hD;
    step(200);
    chk("hold_cnt", pcnt - base, 1);
    chk("hold_last", lastp, 4'h2);
    chk("hold_down", kif.key_down, 4'h2);
    kif.key_raw = 4'hF;
    step(8);
    chk("hold_rel", pcnt - base, 1);
    kif.key_raw = 4'hD;
    step(8);
    chk("hold_repress", pcnt - base, 2);
    kif.key_raw = 4'hF;
    step(8);

    // Bounce on KEY2: 2 low / 2 high for 20 cycles, then held low.
    base = pcnt;
    for (int p = 0; p < 5; p++) begin
      kif.key_raw = 4'hB;
      step(2);
      chk("bnc_lo", kif.key_down[2], 1'b0);
      kif.key_raw = 4'hF;
      step(2);
      chk("bnc_hi", kif.key_down[2], 1'b0);
    end
    chk("bnc_nop", pcnt - base, 0);
    kif.key_raw = 4'hB;
    step(6);
    chk("bnc_p6", kif.key_pulse, 4'h0);
    step(1);
    chk("bnc_p7", kif.key_pulse, 4'h4);
    step(5);
    chk("bnc_cnt", pcnt - base, 1);
    kif.key_raw = 4'hF;
    step(8);

    // Lockout: KEY0 held, KEY3 pressed.
    base = pcnt;
    rbase = rcnt;
    kif.key_raw = 4'hE;
    step(7);
    chk("lk_k0", kif.key_pulse, 4'h1);
    kif.key_raw = 4'h6;
    step(7);
    chk("lk_rej", kif.reject_pulse, 1'b1);
    chk("lk_nop", kif.key_pulse, 4'h0);
    step(1);
    chk("lk_rej1", kif.reject_pulse, 1'b0);
    chk("lk_rcnt", rcnt - rbase, 1);
    chk("lk_pcnt", pcnt - base, 1);
    kif.key_raw = 4'hF;
    step(8);
    kif.key_raw = 4'h7;
    step(7);
    chk("lk_k3", kif.key_pulse, 4'h8);
    kif.key_raw = 4'hF;
    step(8);

    // Reset mid-pulse with KEY2 held.
    kif.key_raw = 4'hB;
    step(7);
    chk("rs_pre", kif.key_pulse, 4'h4);
    reset = 1'b1;
    #1;
    chk("rs_pulse", kif.key_pulse, 4'h0);
    chk("rs_rej", kif.reject_pulse, 1'b0);
    chk("rs_down", kif.key_down, 4'hF);
    chk("rs_any", kif.any_down, 1'b1);
    step(3);
    base = pcnt;
    reset = 1'b0;
    step(20);
    chk("rs_held", pcnt - base, 0);
    chk("rs_hdown", kif.key_down, 4'h4);
    kif.key_raw = 4'hF;
    step(8);
    chk("rs_rel", kif.key_down, 4'h0);
    kif.key_raw = 4'hB;
    step(7);
    chk("rs_k2", kif.key_pulse, 4'h4);
    step(3);
    chk("rs_cnt", pcnt - base, 1);
    kif.key_raw = 4'hF;
    step(8);

    chk("pulse_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
